// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris feeder: round length, piece geometry, FSM states.
package tetris_pkg;

  localparam int ROUND_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } feeder_state_e;

  // Horizontal footprint of each tetromino code, in columns.
  function automatic logic [2:0] piece_width(input logic [2:0] code);
    case (code)
      3'd0:    return 3'd2;
      3'd1:    return 3'd1;
      3'd2:    return 3'd4;
      3'd3:    return 3'd2;
      3'd4:    return 3'd3;
      3'd5:    return 3'd2;
      3'd6:    return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

  // Rightmost legal leftmost-column for a piece.
  function automatic logic [2:0] max_col(input logic [2:0] code);
    return 3'd6 - piece_width(code);
  endfunction

endpackage

// File: rtl/tetris_piece_fifo.sv
// Synchronous FIFO holding {piece, position} entries; pops are refused when empty.
module tetris_piece_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; validity is tracked by count, so clearing it only costs logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: non-blocking assignments keep every register reading pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tetris_feeder.sv
// Feeds buffered (piece, position) pairs to the tetris engine one at a time,
// tracks rounds and discards the rest of a round after an engine fail.
module tetris_feeder #(
  parameter int DEPTH     = 16,
  parameter int ROUND_LEN = tetris_pkg::ROUND_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [2:0] host_piece,
  input  logic [2:0] host_pos,
  output logic       in_valid,
  output logic [2:0] tetrominoes,
  output logic [2:0] position,
  input  logic       score_valid,
  input  logic       fail,
  input  logic [3:0] score,
  output logic       round_done,
  output logic       round_fail,
  output logic [3:0] round_score,
  output logic       clamped,
  output logic       proto_err
);

  import tetris_pkg::*;

  localparam int IDX_W = $clog2(ROUND_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUND_LEN - 1);

  feeder_state_e    state_q, state_d;
  logic [IDX_W-1:0] piece_idx, idx_d;
  logic [IDX_W-1:0] remain, remain_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [5:0]       fifo_rdata;
  logic             issue, round_end;
  logic [2:0]       pop_piece, pop_pos, pop_limit, pop_pos_clamped;
  logic             pop_over;

  tetris_piece_fifo #(.DEPTH(DEPTH), .WIDTH(6)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host_valid),
    .wdata ({host_piece, host_pos}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign host_ready      = !fifo_full;
  assign pop_piece       = fifo_rdata[5:3];
  assign pop_pos         = fifo_rdata[2:0];
  assign pop_limit       = max_col(pop_piece);
  assign pop_over        = (pop_pos > pop_limit);
  assign pop_pos_clamped = pop_over ? pop_limit : pop_pos;

  // Next-state and control strobes for the issue / wait / flush sequence.
  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    issue     = 1'b0;
    round_end = 1'b0;
    idx_d     = piece_idx;
    remain_d  = remain;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          issue    = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (score_valid) begin
          if (fail && piece_idx != LAST_IDX) begin
            remain_d  = LAST_IDX - piece_idx;
            idx_d     = '0;
            round_end = 1'b1;
            state_d   = FLUSH;
          end else if (fail || piece_idx == LAST_IDX) begin
            idx_d     = '0;
            round_end = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d   = piece_idx + IDX_W'(1);
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (remain == '0) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          remain_d = remain - IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round progress, engine-facing outputs and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      piece_idx   <= '0;
      remain      <= '0;
      in_valid    <= 1'b0;
      tetrominoes <= '0;
      position    <= '0;
      round_done  <= 1'b0;
      round_fail  <= 1'b0;
      round_score <= '0;
      clamped     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      piece_idx   <= idx_d;
      remain      <= remain_d;
      in_valid    <= issue;
      tetrominoes <= issue ? pop_piece : 3'd0;
      position    <= issue ? pop_pos_clamped : 3'd0;
      round_done  <= round_end;
      if (round_end) begin
        round_fail  <= fail;
        round_score <= score;
      end
      if (fifo_pop && pop_over) clamped <= 1'b1;
      if (score_valid && state_q != WAIT) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tetris_feeder.sv
// Self-checking bench for tetris_feeder: transaction-level scoreboard plus engine model.
module tb_tetris_feeder;

  localparam int DEPTH = 16;
  localparam int RLEN  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_valid, host_ready;
  logic [2:0] host_piece, host_pos;
  logic       in_valid;
  logic [2:0] tetrominoes, position;
  logic       score_valid, fail;
  logic [3:0] score;
  logic       round_done, round_fail;
  logic [3:0] round_score;
  logic       clamped, proto_err;

  tetris_feeder #(.DEPTH(DEPTH), .ROUND_LEN(RLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_piece  (host_piece),
    .host_pos    (host_pos),
    .in_valid    (in_valid),
    .tetrominoes (tetrominoes),
    .position    (position),
    .score_valid (score_valid),
    .fail        (fail),
    .score       (score),
    .round_done  (round_done),
    .round_fail  (round_fail),
    .round_score (round_score),
    .clamped     (clamped),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  int         widths [8] = '{2, 1, 4, 2, 3, 2, 2, 3};
  logic [5:0] stim[$];
  logic [5:0] exp_q[$];
  int         flush_pending, idx, resp_delay, n_resp;
  bit         exp_clamped, exp_proto, outstanding, fixed_delay;
  bit         rd_due, rd_fail_exp;
  logic [3:0] rd_score_exp, score_hold;
  int         cyc, last_iv, n_issued, n_rounds, n_fail_rounds, n_pushed;
  int         first_push_cyc, first_iv_cyc;

  function automatic logic [2:0] exp_pos(input logic [2:0] code, input logic [2:0] pos);
    int lim;
    lim = 6 - widths[code];
    return (int'(pos) > lim) ? 3'(lim) : pos;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    flush_pending = 0; idx = 0; resp_delay = 0; n_resp = 0;
    exp_clamped = 0; exp_proto = 0; outstanding = 0;
    rd_due = 0; rd_fail_exp = 0; rd_score_exp = 0; score_hold = 0;
    cyc = 0; last_iv = -1; n_issued = 0; n_rounds = 0; n_fail_rounds = 0; n_pushed = 0;
    first_push_cyc = -1; first_iv_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_valid"}, in_valid, 0);
    check({tag, "_tetrominoes"}, tetrominoes, 0);
    check({tag, "_position"}, position, 0);
    check({tag, "_round_done"}, round_done, 0);
    check({tag, "_round_fail"}, round_fail, 0);
    check({tag, "_round_score"}, round_score, 0);
    check({tag, "_clamped"}, clamped, 0);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_host_ready"}, host_ready, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    host_valid = 0; host_piece = 0; host_pos = 0;
    score_valid = 0; fail = 0; score = 0;
    stim.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) stim.push_back({3'($urandom), 3'($urandom)});
  endtask

  // Checks what the DUT produced on the last rising edge (called at negedge).
  task automatic observe();
    logic [5:0] e;
    cyc++;
    if (in_valid === 1'b1) begin
      check("in_valid_while_outstanding", outstanding, 0);
      if (last_iv >= 0) check("in_valid_gap_ge2", (cyc - last_iv) >= 2, 1);
      last_iv = cyc;
      if (n_issued == 0) first_iv_cyc = cyc;
      while (flush_pending > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (exp_pos(e[5:3], e[2:0]) != e[2:0]) exp_clamped = 1'b1;
        flush_pending--;
      end
      if (flush_pending != 0 || exp_q.size() == 0) begin
        check("issue_without_piece", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (exp_pos(e[5:3], e[2:0]) != e[2:0]) exp_clamped = 1'b1;
        check("tetrominoes", tetrominoes, e[5:3]);
        check("position", position, exp_pos(e[5:3], e[2:0]));
        check("clamped", clamped, exp_clamped);
      end
      n_issued++;
      outstanding = 1'b1;
      resp_delay = fixed_delay ? 0 : $urandom_range(0, 2);
    end else begin
      check("idle_tetrominoes", tetrominoes, 0);
      check("idle_position", position, 0);
    end
    check("round_done", round_done, rd_due);
    if (rd_due) begin
      check("round_fail", round_fail, rd_fail_exp);
      check("round_score", round_score, rd_score_exp);
      score_hold = rd_score_exp;
      n_rounds++;
      if (rd_fail_exp) n_fail_rounds++;
    end
    check("round_score_hold", round_score, score_hold);
    check("proto_err", proto_err, exp_proto);
    rd_due = 0;
  endtask

  // Engine model: answers each issued piece once; fail_at<0 random, 0 never, k = k-th response.
  task automatic engine(input int fail_at, input int max_resp);
    bit f;
    logic [3:0] sc;
    score_valid = 0; fail = 1'($urandom); score = 4'($urandom);
    if (outstanding && n_resp < max_resp) begin
      if (resp_delay > 0) resp_delay--;
      else begin
        n_resp++;
        f  = (fail_at < 0) ? ($urandom_range(0, 5) == 0) : (n_resp == fail_at);
        sc = 4'($urandom);
        score_valid = 1; fail = f; score = sc;
        outstanding = 0;
        if (f || idx == RLEN - 1) begin
          rd_due = 1; rd_fail_exp = f; rd_score_exp = sc;
          if (f) flush_pending = RLEN - 1 - idx;
          idx = 0;
        end else begin
          idx++;
        end
      end
    end
  endtask

  task automatic push_step(input bit gate);
    host_valid = 0; host_piece = 3'($urandom); host_pos = 3'($urandom);
    if (stim.size() > 0 && gate) begin
      host_valid = 1;
      {host_piece, host_pos} = stim[0];
      if (host_ready) begin
        exp_q.push_back(stim.pop_front());
        if (n_pushed == 0) first_push_cyc = cyc;
        n_pushed++;
      end
    end
  endtask

  task automatic run_stream(input int fail_at, input int max_resp, input bit bursty);
    bit done = 0;
    n_resp = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      observe();
      engine(fail_at, max_resp);
      push_step(bursty ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (stim.size() == 0 &&
          ((!outstanding && exp_q.size() <= flush_pending) ||
           (outstanding && n_resp >= max_resp)))
        done = 1;
    end
    if (!done) check("stream_timeout", 0, 1);
    @(negedge clk);
    observe();
    score_valid = 0; fail = 0; host_valid = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    host_valid = 0; host_piece = 0; host_pos = 0;
    score_valid = 0; fail = 0; score = 0;
    fixed_delay = 1;
    model_reset();

    // Test 1: one clean round of O pieces, engine answering one cycle after each in_valid.
    do_reset();
    for (int i = 0; i < 16; i++) stim.push_back({3'd0, 3'((i % 3) * 2)});
    run_stream(0, 1000, 0);
    check("t1_issued", n_issued, 16);
    check("t1_rounds", n_rounds, 1);
    check("t1_fail_rounds", n_fail_rounds, 0);

    // Test 2: fail on the 5th response; 11 pieces discarded, next round runs to completion.
    do_reset();
    fill_random(32);
    run_stream(5, 1000, 0);
    check("t2_issued", n_issued, 21);
    check("t2_rounds", n_rounds, 2);
    check("t2_fail_rounds", n_fail_rounds, 1);

    // Test 3: clamping, and push-to-issue latency.
    do_reset();
    stim.push_back({3'd1, 3'd5});
    stim.push_back({3'd2, 3'd5});
    stim.push_back({3'd1, 3'd5});
    run_stream(0, 1000, 0);
    check("t3_issued", n_issued, 3);
    check("t3_clamped_final", clamped, 1);
    check("t3_latency", first_iv_cyc - first_push_cyc, 2);

    // Test 4: engine stalled; FIFO fills, host_ready returns after the next pop.
    do_reset();
    fill_random(DEPTH + 8);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      observe();
      check("t4_ready_vs_count", host_ready, (n_pushed - n_issued) < DEPTH);
      push_step(1'b1);
    end
    stim.delete();
    check("t4_accepted", n_pushed, DEPTH + 1);
    @(negedge clk);
    observe();
    check("t4_full", host_ready, 0);
    host_valid = 0;
    n_resp = 0;
    engine(0, 1);
    @(negedge clk);
    observe();
    check("t4_ready_before_pop", host_ready, 0);
    score_valid = 0; fail = 0;
    @(negedge clk);
    observe();
    check("t4_popped", in_valid, 1);
    check("t4_ready_after_pop", host_ready, 1);

    // Test 5: score_valid in IDLE flags proto_err and changes nothing else.
    do_reset();
    @(negedge clk);
    observe();
    score_valid = 1; fail = 1; score = 4'd9;
    @(negedge clk);
    exp_proto = 1;
    observe();
    score_valid = 0; fail = 0;
    fill_random(16);
    run_stream(0, 1000, 0);
    check("t5_issued", n_issued, 16);
    check("t5_rounds", n_rounds, 1);

    // Test 6: reset while waiting on piece 7, then a fresh round starts at piece 0.
    do_reset();
    fill_random(8);
    stim[3] = {3'd2, 3'd7};
    run_stream(0, 7, 0);
    check("t6_issued_before_reset", n_issued, 8);
    check("t6_clamped_before_reset", clamped, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_midreset");
    @(negedge clk);
    model_reset();
    stim.delete();
    rst_n = 1'b1;
    fill_random(16);
    run_stream(0, 1000, 1);
    check("t6_issued_after", n_issued, 16);
    check("t6_rounds_after", n_rounds, 1);

    // Random traffic: bursty host, random engine delay and random fails.
    do_reset();
    fixed_delay = 0;
    fill_random(150);
    run_stream(-1, 100000, 1);
    check("rand_all_pushed", n_pushed, 150);
    check("rand_proto_err", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
